// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline boundary with a 2-entry skid buffer, resolving BEQ and its target at capture.
// Optional performance counters (stall_cnt, br_cnt) are enabled by defining EX_MEM_PERF_CNT_EN.
module ex_mem_stage #(
  parameter int unsigned DW = 32,
  parameter int unsigned RW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] res,
  input  logic          zf,
  input  logic [DW-1:0] wdata,
  input  logic [RW-1:0] rd,
  input  logic [4:0]    ctrl,
  input  logic [DW-1:0] pc4,
  input  logic [DW-1:0] imm,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_res,
  output logic [DW-1:0] out_wdata,
  output logic [RW-1:0] out_rd,
  output logic [3:0]    out_ctrl,
  output logic [DW-1:0] out_target,
  output logic          pc_src
`ifdef EX_MEM_PERF_CNT_EN
  ,
  output logic [31:0]   stall_cnt,
  output logic [31:0]   br_cnt
`endif
);

  typedef struct packed {
    logic [DW-1:0] res;
    logic          zf;
    logic [DW-1:0] wdata;
    logic [RW-1:0] rd;
    logic [4:0]    ctrl;
    logic [DW-1:0] target;
  } entry_t;

  entry_t m_q, m_d, s_q, s_d, in_entry;
  logic   m_valid_q, m_valid_d;
  logic   s_valid_q, s_valid_d;
  logic   in_ready_q, in_ready_d;
  logic   in_xfer, out_xfer;

  assign in_xfer  = in_valid & in_ready_q;
  assign out_xfer = m_valid_q & out_ready;

  always_comb begin
    in_entry.res    = res;
    in_entry.zf     = zf;
    in_entry.wdata  = wdata;
    in_entry.rd     = rd;
    in_entry.ctrl   = ctrl;
    in_entry.target = pc4 + {imm[DW-3:0], 2'b00};
  end

  always_comb begin
    m_d       = m_q;
    s_d       = s_q;
    m_valid_d = m_valid_q;
    s_valid_d = s_valid_q;
    if (flush) begin
      m_valid_d = 1'b0;
      s_valid_d = 1'b0;
    end else if (s_valid_q) begin
      // S full implies M full and in_ready low, so only the S->M move can happen
      if (out_xfer) begin
        m_d       = s_q;
        s_valid_d = 1'b0;
      end
    end else if (!m_valid_q || out_xfer) begin
      m_valid_d = in_xfer;
      if (in_xfer) m_d = in_entry;
    end else if (in_xfer) begin
      s_d       = in_entry;
      s_valid_d = 1'b1;
    end
    in_ready_d = ~s_valid_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_q        <= '0;
      s_q        <= '0;
      m_valid_q  <= 1'b0;
      s_valid_q  <= 1'b0;
      in_ready_q <= 1'b1;
    end else begin
      m_q        <= m_d;
      s_q        <= s_d;
      m_valid_q  <= m_valid_d;
      s_valid_q  <= s_valid_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = m_valid_q;
  assign out_res    = m_q.res;
  assign out_wdata  = m_q.wdata;
  assign out_rd     = m_q.rd;
  assign out_ctrl   = m_q.ctrl[4:1];
  assign out_target = m_q.target;
  assign pc_src     = m_valid_q & m_q.ctrl[0] & m_q.zf;

`ifdef EX_MEM_PERF_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] br_cnt_q, br_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    br_cnt_d    = br_cnt_q;
    if (m_valid_q && !out_ready) stall_cnt_d = stall_cnt_q + 32'd1;
    if (out_xfer && pc_src)      br_cnt_d    = br_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
      br_cnt_q    <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      br_cnt_q    <= br_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign br_cnt    = br_cnt_q;
`endif

endmodule

// File: tb/tb_ex_mem_stage.sv
// Self-checking bench for ex_mem_stage: directed scenarios plus randomized traffic
// against a queue-based model of a 2-deep FIFO stage.
module tb_ex_mem_stage;
  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, zf, out_valid, out_ready, pc_src;
  logic [31:0] res, wdata, pc4, imm, out_res, out_wdata, out_target;
  logic [4:0]  rd, ctrl, out_rd;
  logic [3:0]  out_ctrl;
`ifdef EX_MEM_PERF_CNT_EN
  logic [31:0] stall_cnt, br_cnt;
`endif

  int npass = 0;
  int ncheck = 0;

  typedef struct {
    logic [31:0] res;
    logic        zf;
    logic [31:0] wdata;
    logic [4:0]  rd;
    logic [4:0]  ctrl;
    logic [31:0] target;
  } exp_t;

  exp_t        q[$];
  logic [31:0] exp_stall = 0;
  logic [31:0] exp_br = 0;

  ex_mem_stage #(.DW(32), .RW(5)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .res(res), .zf(zf), .wdata(wdata), .rd(rd), .ctrl(ctrl), .pc4(pc4), .imm(imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_res(out_res), .out_wdata(out_wdata),
    .out_rd(out_rd), .out_ctrl(out_ctrl), .out_target(out_target), .pc_src(pc_src)
`ifdef EX_MEM_PERF_CNT_EN
    , .stall_cnt(stall_cnt), .br_cnt(br_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Model step for the coming edge, then move to just after it.
  task automatic tick();
    bit   ov, ir;
    exp_t e;
    ov = (q.size() > 0);
    ir = (q.size() < 2);
    if (ov && !out_ready) exp_stall = exp_stall + 1;
    if (ov && out_ready && q[0].ctrl[0] && q[0].zf) exp_br = exp_br + 1;
    if (flush) q.delete();
    else begin
      if (ov && out_ready) void'(q.pop_front());
      if (in_valid && ir) begin
        e.res = res; e.zf = zf; e.wdata = wdata; e.rd = rd; e.ctrl = ctrl;
        e.target = pc4 + imm * 32'd4;
        q.push_back(e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] r, input logic z, input logic [4:0] d,
                       input logic [4:0] c, input logic [31:0] p, input logic [31:0] i);
    in_valid = 1'b1; res = r; zf = z; wdata = $urandom; rd = d; ctrl = c; pc4 = p; imm = i;
  endtask

  task automatic test_reset();
    #12;
    ncheck++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid got=%b exp=0", out_valid);
    else npass++;
    ncheck++; if (in_ready !== 1'b1) $display("FAIL rst_in_ready got=%b exp=1", in_ready);
    else npass++;
    ncheck++; if (pc_src !== 1'b0) $display("FAIL rst_pc_src got=%b exp=0", pc_src); else npass++;
    ncheck++;
    if ({out_res, out_wdata, out_rd, out_ctrl, out_target} !== '0)
      $display("FAIL rst_data got=%h/%h/%h/%h/%h exp=0", out_res, out_wdata, out_rd, out_ctrl,
               out_target);
    else npass++;
    @(negedge clk);
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single();
    out_ready = 1'b1;
    drive(32'h10, 1'b0, 5'd3, 5'b10000, $urandom, $urandom);
    tick();
    in_valid = 1'b0;
    ncheck++; if (out_valid !== 1'b1) $display("FAIL single_valid got=%b exp=1", out_valid);
    else npass++;
    ncheck++; if (out_res !== 32'h10) $display("FAIL single_res got=%h exp=10", out_res);
    else npass++;
    ncheck++; if (out_rd !== 5'd3) $display("FAIL single_rd got=%0d exp=3", out_rd); else npass++;
    ncheck++; if (out_ctrl !== 4'b1000) $display("FAIL single_ctrl got=%b exp=1000", out_ctrl);
    else npass++;
    ncheck++; if (pc_src !== 1'b0) $display("FAIL single_pc_src got=%b exp=0", pc_src);
    else npass++;
    tick();
    ncheck++; if (out_valid !== 1'b0) $display("FAIL single_drain got=%b exp=0", out_valid);
    else npass++;
  endtask

  task automatic test_branch();
    out_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      drive($urandom, (k == 0), $urandom, 5'b00001, 32'h40, 32'hFFFF_FFFC);
      tick();
      in_valid = 1'b0;
      ncheck++;
      if (out_target !== 32'h30) $display("FAIL br_target zf=%0d got=%h exp=30", k == 0, out_target);
      else npass++;
      ncheck++;
      if (pc_src !== (k == 0)) $display("FAIL br_pc_src zf=%0d got=%b exp=%b", k == 0, pc_src, k == 0);
      else npass++;
      tick();
    end
  endtask

  task automatic test_wrap();
    out_ready = 1'b1;
    drive($urandom, 1'b1, $urandom, 5'b00001, 32'hFFFF_FFFC, 32'h1);
    tick();
    in_valid = 1'b0;
    ncheck++; if (out_target !== 32'h0) $display("FAIL wrap_target got=%h exp=0", out_target);
    else npass++;
    tick();
  endtask

  task automatic test_back_to_back();
    logic [31:0] got[$];
    bit          acc;
    out_ready = 1'b0;
    drive(32'd1, 1'b0, 5'd1, 5'b10000, $urandom, $urandom);
    tick();
    ncheck++; if (in_ready !== 1'b1) $display("FAIL bp_ready1 got=%b exp=1", in_ready);
    else npass++;
    res = 32'd2;
    tick();
    res = 32'd3;
    for (int c = 0; c < 2; c++) begin
      ncheck++;
      if (in_ready !== 1'b0 || out_res !== 32'd1)
        $display("FAIL bp_hold c=%0d got ready=%b res=%0d exp ready=0 res=1", c, in_ready, out_res);
      else npass++;
      tick();
    end
    out_ready = 1'b1;
    for (int c = 0; c < 20 && got.size() < 4; c++) begin
      acc = in_valid && in_ready;
      if (out_valid) got.push_back(out_res);
      tick();
      if (acc) begin
        if (res == 32'd3) res = 32'd4;
        else in_valid = 1'b0;
      end
    end
    ncheck++; if (got.size() != 4) $display("FAIL bp_count got=%0d exp=4", got.size());
    else npass++;
    for (int i = 0; i < got.size() && i < 4; i++) begin
      ncheck++;
      if (got[i] !== 32'(i + 1)) $display("FAIL bp_order i=%0d got=%0d exp=%0d", i, got[i], i + 1);
      else npass++;
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_flush();
    int seen;
    out_ready = 1'b0;
    for (int n = 1; n <= 2; n++) begin
      for (int k = 0; k < n; k++) begin
        drive(32'd5 + 32'(k), 1'b0, 5'd2, 5'b10000, $urandom, $urandom);
        tick();
      end
      flush = 1'b1;
      drive(32'd9, 1'b0, 5'd9, 5'b10000, $urandom, $urandom);
      tick();
      flush = 1'b0;
      in_valid = 1'b0;
      ncheck++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1)
        $display("FAIL flush n=%0d got valid=%b ready=%b exp valid=0 ready=1", n, out_valid,
                 in_ready);
      else npass++;
    end
    out_ready = 1'b1;
    seen = 0;
    for (int c = 0; c < 3; c++) begin
      if (out_valid) seen++;
      tick();
    end
    ncheck++; if (seen != 0) $display("FAIL flush_leak got=%0d beats exp=0", seen); else npass++;
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    drive($urandom, 1'b1, $urandom, 5'b00001, $urandom, $urandom);
    tick();
    drive($urandom, 1'b1, $urandom, 5'b00001, $urandom, $urandom);
    tick();
    in_valid = 1'b0;
    ncheck++;
    if (pc_src !== 1'b1 || in_ready !== 1'b0)
      $display("FAIL arst_pre got pc_src=%b ready=%b exp pc_src=1 ready=0", pc_src, in_ready);
    else npass++;
    #2 rst = 1'b1;
    #1;
    ncheck++;
    if (out_valid !== 1'b0 || pc_src !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL arst got valid=%b pc_src=%b ready=%b exp 0/0/1", out_valid, pc_src, in_ready);
    else npass++;
    q.delete();
    exp_stall = 0;
    exp_br = 0;
`ifdef EX_MEM_PERF_CNT_EN
    ncheck++;
    if (stall_cnt !== 32'd0 || br_cnt !== 32'd0)
      $display("FAIL arst_cnt got stall=%0d br=%0d exp 0/0", stall_cnt, br_cnt);
    else npass++;
`endif
    @(negedge clk);
    rst = 1'b0;
    tick();
  endtask

  task automatic test_random();
    bit ov;
    for (int c = 0; c < 400; c++) begin
      ov = (q.size() > 0);
      ncheck++;
      if (out_valid !== ov || in_ready !== (q.size() < 2))
        $display("FAIL rnd_hs c=%0d got valid=%b ready=%b exp valid=%b ready=%b", c, out_valid,
                 in_ready, ov, q.size() < 2);
      else npass++;
      if (ov) begin
        ncheck++;
        if (out_res !== q[0].res || out_wdata !== q[0].wdata || out_rd !== q[0].rd ||
            out_ctrl !== q[0].ctrl[4:1] || out_target !== q[0].target)
          $display("FAIL rnd_data c=%0d got %h/%h/%h/%h/%h exp %h/%h/%h/%h/%h", c, out_res,
                   out_wdata, out_rd, out_ctrl, out_target, q[0].res, q[0].wdata, q[0].rd,
                   q[0].ctrl[4:1], q[0].target);
        else npass++;
      end
      ncheck++;
      if (pc_src !== (ov && q[0].ctrl[0] && q[0].zf))
        $display("FAIL rnd_pc_src c=%0d got=%b exp=%b", c, pc_src, ov && q[0].ctrl[0] && q[0].zf);
      else npass++;
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 6);
      flush     = ($urandom_range(0, 99) < 3);
      res = $urandom; zf = $urandom_range(0, 1); wdata = $urandom; rd = 5'($urandom);
      ctrl = 5'($urandom); pc4 = $urandom; imm = $urandom;
      tick();
    end
    flush = 1'b0;
    in_valid = 1'b0;
`ifdef EX_MEM_PERF_CNT_EN
    ncheck++;
    if (stall_cnt !== exp_stall || br_cnt !== exp_br)
      $display("FAIL rnd_cnt got stall=%0d br=%0d exp %0d/%0d", stall_cnt, br_cnt, exp_stall,
               exp_br);
    else npass++;
`endif
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    res = '0; zf = 1'b0; wdata = '0; rd = '0; ctrl = '0; pc4 = '0; imm = '0;
    test_reset();
    test_single();
    test_branch();
    test_wrap();
    test_back_to_back();
    test_flush();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", npass, ncheck);
    $finish;
  end
endmodule

// File: doc/ex_mem_stage.md
Name: ex_mem_stage

Overview:
Pipeline boundary directly downstream of the ALU. It captures ALU result and zero flag, store data, destination register, and MEM/WB control bits, and resolves BEQ (branch & zf) and its target. A 2-entry skid buffer with valid/ready handshakes on both sides makes in_ready a pure register output. Consumer is the data-memory stage.

Parameters:
DW, 32, datapath width (res, wdata, pc, imm, target).
RW, 5, register-address width (rd).

Ports:
clk  in  1  clock, rising-edge.
rst  in  1  asynchronous, active-high reset.
flush  in  1  synchronous kill of all held entries.
in_valid  in  1  upstream beat valid.
in_ready  out  1  stage can accept a beat; registered.
res  in  DW  ALU result.
zf  in  1  ALU zero flag.
wdata  in  DW  store data (rs2 value).
rd  in  RW  destination register.
ctrl  in  5  {reg_write, mem_read, mem_write, mem_to_reg, branch}, MSB first.
pc4  in  DW  PC+4 of the instruction.
imm  in  DW  sign-extended branch offset, in words.
out_valid  out  1  downstream beat valid.
out_ready  in  1  downstream accepts.
out_res  out  DW  registered res.
out_wdata  out  DW  registered wdata.
out_rd  out  RW  registered rd.
out_ctrl  out  4  registered {reg_write, mem_read, mem_write, mem_to_reg}.
out_target  out  DW  pc4 + (imm << 2), modulo 2^DW.
pc_src  out  1  out_valid & branch & zf of the head entry.

Behaviour:
- Reset (async, rst=1): main and skid valids = 0. All out_* data = 0. out_valid = 0, pc_src = 0, in_ready = 1. No beat is captured while rst is high.
- Storage: main entry M drives outputs; skid entry S. Payload = {res, zf, wdata, rd, ctrl, computed target}. The target is computed at capture, so the adder sits on the input side.
- Transfer in: in_valid & in_ready. Transfer out: out_valid & out_ready.
- in_ready = !S.valid, registered.
- Per cycle, when flush=0:
  - M empty, or M draining, with S empty: an input beat loads M.
  - M full, not draining, input beat: the beat loads S. in_ready drops next cycle.
  - M draining, S full: S moves to M. in_ready rises next cycle. No input can arrive, because in_ready was 0.
  - M draining, no input, S empty: M.valid clears.
- Latency: one cycle from input transfer to out_valid when the stage is empty. Full throughput of one beat per cycle while out_ready=1.
- Ordering: strictly FIFO. Payload is never modified while out_valid=1 and out_ready=0.
- flush=1: on the next edge M.valid = S.valid = 0 and in_ready = 1. A simultaneous input beat is discarded. A simultaneous output transfer still counts as completed. Data fields keep their old values and are don't-care.
- pc_src is combinational from M: out_valid & M.branch & M.zf. It is 0 whenever out_valid = 0.
- Arithmetic: the target wraps modulo 2^DW. imm << 2 drops the top two bits.
- Reset mid-operation: everything is lost immediately and there is no pending output.

Optional Feature:
Macro EX_MEM_PERF_CNT_EN.
- Defined: adds two 32-bit outputs, stall_cnt and br_cnt.
  - stall_cnt increments on every cycle with out_valid & !out_ready.
  - br_cnt increments on every output transfer with pc_src=1.
  - Both counters wrap at 2^32, clear on rst, and are unaffected by flush.
- Not defined: neither the ports nor the counters exist. Behaviour is otherwise identical.

Test Plan:
- Reset, then one beat: res=0x0000_0010, rd=3, ctrl=10000, out_ready=1. Expect out_valid=1 next cycle with out_res=0x10, out_rd=3, out_ctrl=1000, pc_src=0, then out_valid=0.
- Branch taken: ctrl=00001, zf=1, pc4=0x0000_0040, imm=0xFFFF_FFFC. Expect out_target=0x0000_0030 and pc_src=1. Repeat with zf=0: expect pc_src=0 and the same target.
- Backpressure: stream res=1,2,3,4 with out_ready=0 for 3 cycles. Expect in_ready=0 once 2 beats are held, out_res held at 1. After release, outputs 1,2,3,4 in order with no loss or duplication.
- Wrap: pc4=0xFFFF_FFFC, imm=1. Expect out_target=0x0000_0000.
- Flush: hold 2 entries with out_ready=0, then assert flush together with in_valid (res=9). Expect out_valid=0 and in_ready=1 next cycle, and res=9 never appears.
- Async reset: assert rst mid-cycle while 2 entries are held. Expect out_valid=0, pc_src=0, in_ready=1 without waiting for a clock edge. With EX_MEM_PERF_CNT_EN, stall_cnt=0 and br_cnt=0.
